mips16_trace_tx: RTL and testbench
==================================

Name: mips16_trace_tx

Overview:
- Hardware trace transmitter for the mips_16 core; the on-chip counterpart of the simulation bench that watches pc_out/alu_result.
- Samples the core's pc_out and alu_result once per new instruction, buffers the records in a small FIFO, and serialises them on a UART-style 8N1 line.
- Sits beside mips_16 at the top level and drives an off-chip trace pin, so silicon and FPGA runs give the same PC/ALU log the bench monitor prints.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (434 = 115200 baud at 50 MHz); minimum 2.
- DEPTH, 8, FIFO depth in records; power of 2, minimum 2.
- SYNC_BYTE, 8'hA5, first byte of every transmitted record.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  16  core pc_out.
- alu_in  input  16  core alu_result.
- trace_en  input  1  enables sampling; transmission continues regardless.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high whenever the TX FSM is not in IDLE.
- fifo_level  output  $clog2(DEPTH)+1  records currently buffered.
- overflow  output  1  sticky: at least one record was dropped.
- drop_count  output  8  records dropped; saturates at 255.

Behaviour:
- Reset and interface are fixed: one clock (clk); reset is synchronous and active-high. On a clk edge with reset=1: tx=1, tx_busy=0, fifo_level=0, overflow=0, drop_count=0, FIFO empty, FSM=IDLE, first_flag=1, last_pc=0. Reset mid-frame aborts the frame; tx is 1 from the next cycle.
- Capture:
  - Condition is trace_en=1 and (first_flag=1 or pc_in != last_pc).
  - When the condition holds, record {pc_in, alu_in} is pushed on that edge and first_flag clears.
  - last_pc loads pc_in on every edge with trace_en=1.
  - With trace_en=0, nothing is sampled and last_pc holds.
- FIFO:
  - Push is accepted if not full, or if a pop occurs on the same edge.
  - A push while full without a pop is a drop: overflow←1, drop_count increments and saturates at 255; FIFO contents are unchanged.
  - fifo_level is exact, including a simultaneous push and pop (level unchanged).
  - Pointers wrap modulo DEPTH.
- TX FSM: IDLE → START → DATA → STOP → (START for next byte | IDLE).
  - IDLE: if the FIFO is non-empty, pop into a 32-bit holding register, set byte_idx=0, go to START. tx goes low on the following cycle, so pop-to-start-bit latency is 1 cycle.
  - Byte order within a record: SYNC_BYTE, pc[15:8], pc[7:0], alu[15:8], alu[7:0].
  - Each byte is framed as start bit (0), 8 data bits LSB-first, stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles.
  - After STOP: if byte_idx<4, increment it and go to START directly, with no idle gap. Else go to IDLE.
  - IDLE lasts at least 1 cycle (tx=1) between records.
  - One record occupies 50·CLKS_PER_BIT cycles plus 1 IDLE cycle.
- tx_busy=1 in START, DATA and STOP; 0 in IDLE.
- All outputs are registered; tx has no combinational path from the inputs.

Test Plan:
- Reset, then no activity (CLKS_PER_BIT=4, DEPTH=8) → tx=1, tx_busy=0, fifo_level=0, drop_count=0 for 100 cycles.
- trace_en=1, pc_in=0x0002, alu_in=0x1234 held steady → exactly one record captured; tx emits bytes A5,00,02,12,34 in 8N1 LSB-first, 40 cycles per byte, 200 cycles total; pc held steady produces no further records.
- pc_in steps 0x0000, 0x0002, 0x0004 on consecutive cycles with alu_in 0x0001, 0x0002, 0x0003 → three records transmitted back-to-back in that order, with exactly one idle cycle between records and fifo_level peaking at 2 after the first pop.
- 12 distinct PCs on 12 consecutive cycles while the first record is transmitting (DEPTH=8) → 1 popped + 8 buffered, 3 dropped; overflow=1, drop_count=3; the 9 retained records are sent in order.
- pc_in changes every cycle for 300+ records with TX slowed (CLKS_PER_BIT=4) → drop_count saturates at 255; overflow stays 1.
- Reset asserted during DATA of byte 2 → tx=1 and tx_busy=0 the next cycle, fifo_level=0; after release, the first sample with trace_en=1 is captured even if pc_in equals the pre-reset PC.

Source files
------------

// File: rtl/mips16_trace_tx.sv
// Trace transmitter for mips_16: captures {pc, alu} once per new PC into a small FIFO
// and serialises each record as five 8N1 bytes (SYNC, pc hi/lo, alu hi/lo).
module mips16_trace_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          DEPTH        = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              pc_in,
  input  logic [15:0]              alu_in,
  input  logic                     trace_en,
  output logic                     tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Capture and FIFO state
  logic          first_q;
  logic [15:0]   last_pc_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic [7:0]    drop_count_q;

  // Transmitter state
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [31:0]   hold_q, hold_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [7:0]    cur_byte;

  logic capture, full, pop, push, drop;

  assign capture = trace_en && (first_q || (pc_in != last_pc_q));
  assign full    = (level_q == FULL_LVL);
  assign pop     = (state_q == S_IDLE) && (level_q != '0);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc_in, alu_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q      <= 1'b1;
      last_pc_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (trace_en) last_pc_q <= pc_in;
      if (capture)  first_q   <= 1'b0;
      if (push)     wr_ptr_q  <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q  <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      hold_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: every bit lasts CLKS_PER_BIT cycles, bytes chain with no gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          cnt_d   = '0;
          byte_d  = '0;
          hold_d  = mem_q[rd_ptr_q];
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (byte_q == 3'd4) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic, computed from next state so tx and tx_busy come straight from flops
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_d)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = hold_d[31:24];
      3'd2:    cur_byte = hold_d[23:16];
      3'd3:    cur_byte = hold_d[15:8];
      default: cur_byte = hold_d[7:0];
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mips16_trace_tx.sv
// Randomised bench for mips16_trace_tx: a record-level reference model predicts captures,
// drops and transmit timing; a line monitor decodes 8N1 frames and scores them.
module tb_mips16_trace_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int REC   = 50 * CPB;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in, alu_in;
  logic        trace_en;
  logic        tx, tx_busy, overflow;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;

  mips16_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_in(alu_in), .trace_en(trace_en),
    .tx(tx), .tx_busy(tx_busy), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of records plus the time the transmitter frees up
  int          t = 0;
  int          busy_until = 0;
  int          next_free = 0;
  logic        m_first = 1'b1;
  logic [15:0] m_last_pc = '0;
  logic [31:0] m_fifo[$];
  int          m_drop = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] exp_q[$];
  bit          abort_req = 0;

  task automatic model_edge(input logic en, input logic [15:0] pc, input logic [15:0] alu);
    logic popped;
    popped = 1'b0;
    t++;
    if (t >= next_free && m_fifo.size() > 0) begin
      exp_q.push_back(m_fifo.pop_front());
      busy_until = t + REC;
      next_free  = t + REC + 1;
      popped     = 1'b1;
    end
    if (en && (m_first || pc != m_last_pc)) begin
      m_first = 1'b0;
      if (m_fifo.size() < DEPTH) m_fifo.push_back({pc, alu});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (en) m_last_pc = pc;
  endtask

  task automatic compare_outputs();
    logic busy;
    busy = (t < busy_until);
    check("fifo_level", fifo_level, m_fifo.size());
    check("tx_busy", tx_busy, busy);
    check("drop_count", drop_count, m_drop);
    check("overflow", overflow, m_ovf);
    if (!busy) check("tx_idle_high", tx, 1'b1);
  endtask

  // Driver tasks
  task automatic step(input logic en, input logic [15:0] pc, input logic [15:0] alu);
    trace_en = en;
    pc_in    = pc;
    alu_in   = alu;
    @(posedge clk);
    model_edge(en, pc, alu);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    t++;
    m_fifo.delete();
    busy_until = 0;
    next_free  = t + 1;
    m_first    = 1'b1;
    m_last_pc  = '0;
    m_drop     = 0;
    m_ovf      = 1'b0;
    abort_req  = 1;
    @(negedge clk);
    compare_outputs();
    check("reset_tx", tx, 1'b1);
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((m_fifo.size() > 0 || t < next_free) && n < max_cycles) begin
      step(1'b0, 16'h0, 16'h0);
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", n, 0);
    repeat (3) step(1'b0, 16'h0, 16'h0);
  endtask

  // Scoreboard monitor: decode frames off the serial line
  bit          mon_active = 0;
  int          mon_cnt = 0;
  logic [7:0]  cur_byte;
  logic [7:0]  mon_bytes [5];
  logic [31:0] exp_rec;

  always @(negedge clk) begin
    if (abort_req) begin
      abort_req = 0;
      if (mon_active) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mon_active = 0;
      end
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (mon_active && (mon_cnt % CPB) == 1) begin
      int j, pos, k;
      j   = mon_cnt / CPB;
      pos = j % 10;
      k   = j / 10;
      if (pos == 0) check("start_bit", tx, 1'b0);
      else if (pos <= 8) cur_byte[pos-1] = tx;
      else begin
        check("stop_bit", tx, 1'b1);
        mon_bytes[k] = cur_byte;
        if (k == 4) begin
          mon_active = 0;
          if (exp_q.size() == 0) check("unexpected_record", 1, 0);
          else begin
            exp_rec = exp_q.pop_front();
            check("sync_byte", mon_bytes[0], 8'hA5);
            check("record", {mon_bytes[1], mon_bytes[2], mon_bytes[3], mon_bytes[4]}, exp_rec);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [15:0] pc;
    reset    = 1'b0;
    trace_en = 1'b0;
    pc_in    = '0;
    alu_in   = '0;
    @(negedge clk);
    do_reset();

    // Quiet line after reset
    repeat (100) step(1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));

    // Steady PC yields exactly one record
    repeat (250) step(1'b1, 16'h0002, 16'h1234);

    // Three consecutive PCs back-to-back
    step(1'b1, 16'h0000, 16'h0001);
    step(1'b1, 16'h0002, 16'h0002);
    step(1'b1, 16'h0004, 16'h0003);
    drain(2000);

    // Burst of 12 distinct PCs overflows the FIFO
    for (int i = 0; i < 12; i++)
      step(1'b1, 16'(16'h0100 + 2 * i), 16'($urandom_range(0, 65535)));
    drain(3000);

    // Random enables over a small PC set to exercise repeated PCs
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 16'(2 * $urandom_range(0, 3)),
           16'($urandom_range(0, 65535)));
    drain(3000);

    // Distinct PC every cycle drives drop_count into saturation
    pc = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 320; i++) begin
      pc = pc + 16'd2;
      step(1'b1, pc, 16'($urandom_range(0, 65535)));
    end
    check("drop_saturated", drop_count, 8'hFF);
    drain(3000);

    // Reset during DATA of byte 2, then the same PC must be captured again
    do_reset();
    step(1'b1, 16'h00AA, 16'h5555);
    repeat (90) step(1'b1, 16'h00AA, 16'h5555);
    do_reset();
    step(1'b1, 16'h00AA, 16'h7777);
    drain(1000);

    check("exp_q_empty", exp_q.size(), 0);
    check("monitor_idle", mon_active, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
